// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter: NUM_CH cache channels share one memory adaptor.
// One transaction in flight at a time; an IDLE cycle always separates them.
module mem_arbiter_rr #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
    output logic [NUM_CH-1:0]        grant
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_CH-1:0]  req;
    logic [PTR_W-1:0]   sel;
    logic               found;
    logic               sel_wr;
    logic [PTR_W-1:0]   ptr_nxt;

    assign req = ch_read | ch_write;

    // First requester at or after rr_ptr, wrapping upward.
    always_comb begin
        logic [NUM_CH-1:0] sh;
        int c;
        sel   = '0;
        found = 1'b0;
        sh    = '0;
        c     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            c  = (int'(rr_ptr) + k) % NUM_CH;
            sh = req >> c;
            if (!found && sh[0]) begin
                found = 1'b1;
                sel   = PTR_W'(c);
            end
        end
    end

    always_comb begin
        logic [NUM_CH-1:0] wsh;
        wsh    = ch_write >> sel;
        sel_wr = wsh[0];
    end

    assign ptr_nxt = PTR_W'((int'(gnt_idx) + 1) % NUM_CH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            grant       <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state       <= BUSY;
                        gnt_idx     <= sel;
                        grant       <= NUM_CH'(1) << sel;
                        mem_address <= ch_addr[sel*ADDR_W +: ADDR_W];
                        mem_wdata   <= ch_wdata[sel*LINE_W +: LINE_W];
                        mem_write   <= sel_wr;
                        mem_read    <= ~sel_wr;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        grant     <= '0;
                        rr_ptr    <= ptr_nxt;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is suppressed on a reset edge so an abandoned transaction never reports.
    assign ch_resp  = (state == BUSY && mem_resp && !rst) ? grant : '0;
    assign ch_rdata = mem_rdata;

endmodule
